// File: rtl/nmr_bstrm_dpath.sv
// nmr_bstrm_dpath: converts sequencer commands (pattern / constant runs /
// seq_end) into a serial control bitstream on BSTRM_OUT, one bit per CLK.
// A one-entry command buffer feeds an active segment register so that
// consecutive segments are emitted without idle cycles.
// Optional feature: define NMR_BSTRM_DPATH_BITCNT_EN to add the BIT_CNT
// output, a saturating count of cycles with BSTRM_ACTIVE=1.
module nmr_bstrm_dpath #(
    parameter int DATA_WIDTH = 120,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  DPATH_START,
    output logic                  DPATH_BUF_RDY,
    input  logic [DATA_WIDTH-1:0] data_reg,
    input  logic                  seq_end_reg,
    input  logic                  pattern_mode_reg,
    input  logic                  all_1s_mode_reg,
    input  logic                  all_0s_mode_reg,
    input  logic                  ERR_CLR,
    output logic                  BSTRM_OUT,
    output logic                  BSTRM_ACTIVE,
    output logic                  SEQ_DONE,
    output logic                  UNDERRUN,
    output logic                  OVERRUN
`ifdef NMR_BSTRM_DPATH_BITCNT_EN
    ,
    output logic [31:0]           BIT_CNT
`endif
);

    // The remaining-count register must hold both a run length and the
    // pattern length, whichever needs more bits.
    localparam int PAT_CW = $clog2(DATA_WIDTH + 1);
    localparam int REM_W  = (CNT_WIDTH > PAT_CW) ? CNT_WIDTH : PAT_CW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_END  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                  buf_seq_end_q, buf_seq_end_d;
    logic                  buf_pat_q, buf_pat_d;
    logic                  buf_one_q, buf_one_d;
    logic                  buf_zero_q, buf_zero_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic                  seg_pat_q, seg_pat_d;
    logic                  seg_bit_q, seg_bit_d;
    logic                  bstrm_out_q, bstrm_out_d;
    logic                  bstrm_active_q, bstrm_active_d;
    logic                  seq_done_q, seq_done_d;
    logic                  buf_rdy_q, buf_rdy_d;
    logic                  underrun_q, underrun_d;
    logic                  overrun_q, overrun_d;

    logic                  seg_last;
    logic                  xfer;
    logic                  wr_acc;
    logic                  under_set;
    logic [CNT_WIDTH-1:0]  buf_run_len;

    assign buf_run_len = buf_data_q[CNT_WIDTH-1:0];
    assign seg_last    = (rem_q == REM_W'(1));

    // Handshake: the engine takes the buffer whenever it has no further bit of
    // the current segment to drive; a write is accepted into a free or freeing slot.
    always_comb begin
        xfer = 1'b0;
        unique case (state_q)
            S_RUN:   xfer = buf_full_q && seg_last;
            default: xfer = buf_full_q;
        endcase
        wr_acc = DPATH_START && (!buf_full_q || xfer);
    end

    // Next-state logic for the buffer, segment engine and status flags.
    always_comb begin
        state_d        = state_q;
        buf_full_d     = buf_full_q;
        buf_data_d     = buf_data_q;
        buf_seq_end_d  = buf_seq_end_q;
        buf_pat_d      = buf_pat_q;
        buf_one_d      = buf_one_q;
        buf_zero_d     = buf_zero_q;
        shift_d        = shift_q;
        rem_d          = rem_q;
        seg_pat_d      = seg_pat_q;
        seg_bit_d      = seg_bit_q;
        bstrm_out_d    = 1'b0;
        bstrm_active_d = 1'b0;
        seq_done_d     = seq_done_q;
        under_set      = 1'b0;

        if (wr_acc) begin
            buf_full_d    = 1'b1;
            buf_data_d    = data_reg;
            buf_seq_end_d = seq_end_reg;
            buf_pat_d     = pattern_mode_reg;
            buf_one_d     = all_1s_mode_reg;
            buf_zero_d    = all_0s_mode_reg;
        end else if (xfer) begin
            buf_full_d = 1'b0;
        end

        unique case (state_q)
            S_RUN: begin
                if (!seg_last) begin
                    rem_d          = rem_q - REM_W'(1);
                    bstrm_out_d    = seg_pat_q ? shift_q[0] : seg_bit_q;
                    bstrm_active_d = 1'b1;
                    shift_d        = shift_q >> 1;
                end else if (!buf_full_q) begin
                    under_set = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_GAP: begin
                if (!buf_full_q) begin
                    under_set = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_END: begin
                if (wr_acc) begin
                    seq_done_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: ;
        endcase

        // Decode priority: seq_end > pattern > all_1s > all_0s; anything else
        // (including a zero-length run) is a null command that emits nothing.
        if (xfer) begin
            seq_done_d = 1'b0;
            if (buf_seq_end_q) begin
                state_d    = S_END;
                seq_done_d = 1'b1;
            end else if (buf_pat_q) begin
                state_d        = S_RUN;
                seg_pat_d      = 1'b1;
                rem_d          = REM_W'(DATA_WIDTH);
                bstrm_out_d    = buf_data_q[0];
                bstrm_active_d = 1'b1;
                shift_d        = buf_data_q >> 1;
            end else if ((buf_one_q || buf_zero_q) && (buf_run_len != '0)) begin
                state_d        = S_RUN;
                seg_pat_d      = 1'b0;
                seg_bit_d      = buf_one_q;
                rem_d          = REM_W'(buf_run_len);
                bstrm_out_d    = buf_one_q;
                bstrm_active_d = 1'b1;
            end else begin
                state_d = ((state_q == S_RUN) || (state_q == S_GAP)) ? S_GAP : S_IDLE;
            end
        end

        // Sticky error flags: a set in the same cycle beats a clear.
        underrun_d = ERR_CLR ? 1'b0 : underrun_q;
        overrun_d  = ERR_CLR ? 1'b0 : overrun_q;
        if (under_set) begin
            underrun_d = 1'b1;
        end
        if (DPATH_START && !wr_acc) begin
            overrun_d = 1'b1;
        end

        buf_rdy_d = ~buf_full_d;
    end

    // State and output registers; RST forces every output to its idle value at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= S_IDLE;
            buf_full_q     <= 1'b0;
            buf_data_q     <= '0;
            buf_seq_end_q  <= 1'b0;
            buf_pat_q      <= 1'b0;
            buf_one_q      <= 1'b0;
            buf_zero_q     <= 1'b0;
            shift_q        <= '0;
            rem_q          <= '0;
            seg_pat_q      <= 1'b0;
            seg_bit_q      <= 1'b0;
            bstrm_out_q    <= 1'b0;
            bstrm_active_q <= 1'b0;
            seq_done_q     <= 1'b0;
            buf_rdy_q      <= 1'b1;
            underrun_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            buf_full_q     <= buf_full_d;
            buf_data_q     <= buf_data_d;
            buf_seq_end_q  <= buf_seq_end_d;
            buf_pat_q      <= buf_pat_d;
            buf_one_q      <= buf_one_d;
            buf_zero_q     <= buf_zero_d;
            shift_q        <= shift_d;
            rem_q          <= rem_d;
            seg_pat_q      <= seg_pat_d;
            seg_bit_q      <= seg_bit_d;
            bstrm_out_q    <= bstrm_out_d;
            bstrm_active_q <= bstrm_active_d;
            seq_done_q     <= seq_done_d;
            buf_rdy_q      <= buf_rdy_d;
            underrun_q     <= underrun_d;
            overrun_q      <= overrun_d;
        end
    end

    assign BSTRM_OUT     = bstrm_out_q;
    assign BSTRM_ACTIVE  = bstrm_active_q;
    assign SEQ_DONE      = seq_done_q;
    assign DPATH_BUF_RDY = buf_rdy_q;
    assign UNDERRUN      = underrun_q;
    assign OVERRUN       = overrun_q;

`ifdef NMR_BSTRM_DPATH_BITCNT_EN
    logic [31:0] bit_cnt_q, bit_cnt_d;

    // Active-bit counter: restarts with the first command of a new sequence, saturates.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (wr_acc && ((state_q == S_IDLE) || (state_q == S_END))) begin
            bit_cnt_d = '0;
        end else if (bstrm_active_q && (bit_cnt_q != 32'hFFFF_FFFF)) begin
            bit_cnt_d = bit_cnt_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign BIT_CNT = bit_cnt_q;
`endif

endmodule
